// File: rtl/agu_pkg.sv
// Shared types for the LSU address generation unit: mem-op decode, FSM state,
// the registered output beat and the size decode helper.
package agu_pkg;

    typedef enum logic [1:0] {
        OP_MEM_LD  = 2'd0,
        OP_MEM_LDU = 2'd1,
        OP_MEM_ST  = 2'd2,
        OP_MEM_NOP = 2'd3
    } decode_mem_op_t;

    typedef enum logic [0:0] {
        AGU_IDLE   = 1'b0,
        AGU_SECOND = 1'b1
    } agu_state_e;

    // Beat fields are sized for the widest legal configuration; narrower tops use the low bits.
    localparam int AGU_MAX_XLEN  = 64;
    localparam int AGU_MASK_W    = AGU_MAX_XLEN / 8;
    localparam int AGU_MAX_TAG_W = 16;

    typedef struct packed {
        logic [AGU_MAX_XLEN-1:0]  addr;
        logic [AGU_MASK_W-1:0]    mask;
        logic                     ld;
        logic                     misalign;
        logic                     fault;
        logic                     beat;
        logic                     last;
        logic [AGU_MAX_TAG_W-1:0] tag;
    } agu_beat_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/agu_mask_gen.sv
// Byte-enable generation: maps the in-word offset and access size onto two
// consecutive bus words and reports whether the second word is touched.
module agu_mask_gen
    import agu_pkg::*;
#(
    parameter int B_LOG2 = 2
) (
    input  logic [B_LOG2-1:0]      i_lo,
    input  logic [1:0]             i_size,
    output logic [(1<<B_LOG2)-1:0] o_mask0,
    output logic [(1<<B_LOG2)-1:0] o_mask1,
    output logic                   o_cross
);
    localparam int B = 1 << B_LOG2;

    logic [4:0]     w_lo;
    logic [4:0]     w_end;
    logic [2*B-1:0] w_span;

    assign w_lo  = 5'(i_lo);
    assign w_end = w_lo + 5'(size_bytes(i_size));

    // Byte i of the two-word window is enabled when lo <= i < lo+nbytes.
    always_comb begin
        w_span = '0;
        for (int i = 0; i < 2*B; i++) begin
            w_span[i] = (5'(i) >= w_lo) && (5'(i) < w_end);
        end
    end

    assign o_mask0 = w_span[B-1:0];
    assign o_mask1 = w_span[2*B-1:B];
    assign o_cross = w_end > 5'(B);

endmodule

// File: rtl/addr_gen_split_unit.sv
// Pipelined AGU: registers the effective address as a bus-word beat, flags
// misalignment and splits word-crossing accesses into two aligned beats.
module addr_gen_split_unit
    import agu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int SPLIT_MISALIGN = 1,
    parameter int TAG_W          = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  decode_mem_op_t      i_op,
    input  logic [XLEN-1:0]     i_src1,
    input  logic [XLEN-1:0]     i_offset,
    input  logic [1:0]          i_size,
    input  logic [TAG_W-1:0]    i_tag,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [XLEN-1:0]     o_addr,
    output logic [XLEN/8-1:0]   o_mask,
    output logic                o_ld,
    output logic                o_misalign,
    output logic                o_fault,
    output logic                o_beat,
    output logic                o_last,
    output logic [TAG_W-1:0]    o_tag
);
    localparam int B      = XLEN / 8;
    localparam int B_LOG2 = $clog2(B);

    agu_state_e      r_state;
    logic            r_valid;
    agu_beat_t       r_beat;
    logic [XLEN-1:0] r_addr2;
    logic [B-1:0]    r_mask2;

    logic [XLEN-1:0]   w_ea;
    logic [XLEN-1:0]   w_base;
    logic [B_LOG2-1:0] w_lo;
    logic [B-1:0]      w_mask0;
    logic [B-1:0]      w_mask1;
    logic [2:0]        w_align;
    logic              w_cross;
    logic              w_size_err;
    logic              w_fault;
    logic              w_split;
    logic              w_misalign;
    logic              w_accept;
    logic              w_out_hs;
    agu_beat_t         w_first;
    logic              w_unused;

    assign w_ea       = i_src1 + i_offset;
    assign w_lo       = w_ea[B_LOG2-1:0];
    assign w_base     = {w_ea[XLEN-1:B_LOG2], {B_LOG2{1'b0}}};
    assign w_align    = 3'(size_bytes(i_size) - 4'd1);
    assign w_misalign = |(w_ea[2:0] & w_align);
    assign w_size_err = (XLEN == 32) && (i_size == 2'd3);
    assign w_fault    = w_size_err || (w_cross && (SPLIT_MISALIGN == 0));
    assign w_split    = w_cross && !w_fault;

    agu_mask_gen #(.B_LOG2(B_LOG2)) u_mask_gen (
        .i_lo    (w_lo),
        .i_size  (i_size),
        .o_mask0 (w_mask0),
        .o_mask1 (w_mask1),
        .o_cross (w_cross)
    );

    // New requests are only taken in IDLE and only when the output slot frees up this cycle.
    assign o_ready  = (r_state == AGU_IDLE) && (!r_valid || i_ready);
    assign w_accept = i_valid && o_ready;
    assign w_out_hs = r_valid && i_ready;

    // First (or only) beat of an accepted request; faulting accesses carry no byte enables.
    always_comb begin
        w_first          = '0;
        w_first.addr     = AGU_MAX_XLEN'(w_base);
        w_first.mask     = w_fault ? '0 : AGU_MASK_W'(w_mask0);
        w_first.ld       = (i_op == OP_MEM_LD) || (i_op == OP_MEM_LDU);
        w_first.misalign = w_misalign;
        w_first.fault    = w_fault;
        w_first.beat     = 1'b0;
        w_first.last     = !w_split;
        w_first.tag      = AGU_MAX_TAG_W'(i_tag);
    end

    // Output beat register and split FSM; the second beat is staged at accept time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= AGU_IDLE;
            r_valid <= 1'b0;
            r_beat  <= '0;
            r_addr2 <= '0;
            r_mask2 <= '0;
        end else if (i_flush) begin
            r_state <= AGU_IDLE;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                AGU_IDLE: begin
                    if (w_accept) begin
                        r_valid <= 1'b1;
                        r_beat  <= w_first;
                        r_addr2 <= w_base + XLEN'(B);
                        r_mask2 <= w_mask1;
                        r_state <= w_split ? AGU_SECOND : AGU_IDLE;
                    end else if (w_out_hs) begin
                        r_valid <= 1'b0;
                    end
                end
                AGU_SECOND: begin
                    if (w_out_hs && (r_beat.beat == 1'b0)) begin
                        r_beat.addr <= AGU_MAX_XLEN'(r_addr2);
                        r_beat.mask <= AGU_MASK_W'(r_mask2);
                        r_beat.beat <= 1'b1;
                        r_beat.last <= 1'b1;
                    end else if (w_out_hs) begin
                        r_valid <= 1'b0;
                        r_state <= AGU_IDLE;
                    end
                end
                default: begin
                    r_state <= AGU_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid    = r_valid;
    assign o_addr     = r_beat.addr[XLEN-1:0];
    assign o_mask     = r_beat.mask[B-1:0];
    assign o_ld       = r_beat.ld;
    assign o_misalign = r_beat.misalign;
    assign o_fault    = r_beat.fault;
    assign o_beat     = r_beat.beat;
    assign o_last     = r_beat.last;
    assign o_tag      = r_beat.tag[TAG_W-1:0];

    // Upper beat fields are only populated in wider configurations.
    assign w_unused = ^{r_beat.addr, r_beat.mask, r_beat.tag};

endmodule

// File: tb/tb_addr_gen_split_unit.sv
// Self-checking bench for addr_gen_split_unit: directed table, hand-written
// flush/reset sequences, a no-split instance and randomized requests vs a byte-level model.
module tb_addr_gen_split_unit;
    import agu_pkg::*;

    logic           i_clk    = 1'b0;
    logic           i_rst_n  = 1'b0;
    logic           i_flush  = 1'b0;
    logic           i_valid  = 1'b0;
    logic           i_ready  = 1'b0;
    decode_mem_op_t i_op     = OP_MEM_LD;
    logic [31:0]    i_src1   = 32'd0;
    logic [31:0]    i_offset = 32'd0;
    logic [1:0]     i_size   = 2'd0;
    logic [3:0]     i_tag    = 4'd0;
    logic           o_ready, o_valid, o_ld, o_misalign, o_fault, o_beat, o_last;
    logic [31:0]    o_addr;
    logic [3:0]     o_mask, o_tag;

    logic           ns_valid = 1'b0;
    logic           ns_ready = 1'b0;
    logic           ns_o_ready, ns_o_valid, ns_o_ld, ns_o_misalign, ns_o_fault, ns_o_beat, ns_o_last;
    logic [31:0]    ns_o_addr;
    logic [3:0]     ns_o_mask, ns_o_tag;

    int n_checks = 0;
    int n_err    = 0;

    always #5 i_clk = ~i_clk;

    addr_gen_split_unit #(.XLEN(32), .SPLIT_MISALIGN(1), .TAG_W(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_op(i_op), .i_src1(i_src1), .i_offset(i_offset),
        .i_size(i_size), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
        .o_addr(o_addr), .o_mask(o_mask), .o_ld(o_ld), .o_misalign(o_misalign),
        .o_fault(o_fault), .o_beat(o_beat), .o_last(o_last), .o_tag(o_tag)
    );

    addr_gen_split_unit #(.XLEN(32), .SPLIT_MISALIGN(0), .TAG_W(4)) dut_ns (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(ns_valid),
        .o_ready(ns_o_ready), .i_op(i_op), .i_src1(i_src1), .i_offset(i_offset),
        .i_size(i_size), .i_tag(i_tag), .o_valid(ns_o_valid), .i_ready(ns_ready),
        .o_addr(ns_o_addr), .o_mask(ns_o_mask), .o_ld(ns_o_ld), .o_misalign(ns_o_misalign),
        .o_fault(ns_o_fault), .o_beat(ns_o_beat), .o_last(ns_o_last), .o_tag(ns_o_tag)
    );

    typedef struct {
        int          n;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [3:0]  mask0;
        logic [3:0]  mask1;
        logic        ld;
        logic        mis;
        logic        fault;
    } exp_t;

    typedef struct {
        decode_mem_op_t op;
        logic [31:0]    src1;
        logic [31:0]    off;
        logic [1:0]     size;
        exp_t           e;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: walk every byte of the access and bin it into the first or next bus word.
    function automatic exp_t model(input decode_mem_op_t op, input logic [31:0] src1,
                                   input logic [31:0] off, input logic [1:0] size, input bit split);
        exp_t        e;
        logic [31:0] ea;
        logic [31:0] a;
        int          nb;
        ea      = src1 + off;
        nb      = 1 << size;
        e.ld    = (op == OP_MEM_LD) || (op == OP_MEM_LDU);
        e.mis   = (ea & 32'(nb - 1)) != 32'd0;
        e.addr0 = {ea[31:2], 2'b00};
        e.addr1 = e.addr0 + 32'd4;
        e.mask0 = 4'd0;
        e.mask1 = 4'd0;
        e.fault = 1'b0;
        e.n     = 1;
        if (size == 2'd3) begin
            e.fault = 1'b1;
            return e;
        end
        for (int k = 0; k < nb; k++) begin
            a = ea + 32'(k);
            if (a[31:2] == ea[31:2]) e.mask0[a[1:0]] = 1'b1;
            else                     e.mask1[a[1:0]] = 1'b1;
        end
        if (e.mask1 != 4'd0) begin
            if (split) begin
                e.n = 2;
            end else begin
                e.fault = 1'b1;
                e.mask0 = 4'd0;
                e.mask1 = 4'd0;
            end
        end
        return e;
    endfunction

    task automatic check_beat(input string nm, input exp_t e, input int b,
                              input logic [3:0] tg, input logic exp_ready);
        chk({nm, ".valid"}, 64'(o_valid), 64'd1);
        if (!e.fault) chk({nm, ".addr"}, 64'(o_addr), 64'((b == 0) ? e.addr0 : e.addr1));
        chk({nm, ".mask"}, 64'(o_mask), 64'((b == 0) ? e.mask0 : e.mask1));
        chk({nm, ".flags"}, 64'({o_ld, o_misalign, o_fault, o_beat, o_last}),
            64'({e.ld, e.mis, e.fault, b[0], (b == e.n - 1)}));
        chk({nm, ".tag"}, 64'(o_tag), 64'(tg));
        chk({nm, ".ready"}, 64'(o_ready), 64'(exp_ready));
    endtask

    task automatic send(input string nm, input decode_mem_op_t op, input logic [31:0] s1,
                        input logic [31:0] off, input logic [1:0] sz, input logic [3:0] tg);
        i_op = op; i_src1 = s1; i_offset = off; i_size = sz; i_tag = tg; i_valid = 1'b1;
        #1;
        chk({nm, ".accept"}, 64'(o_ready), 64'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic collect(input string nm, input exp_t e, input logic [3:0] tg, input int stall);
        for (int b = 0; b < e.n; b++) begin
            i_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                check_beat({nm, ".hold"}, e, b, tg, 1'b0);
                @(posedge i_clk); #1;
            end
            i_ready = 1'b1;
            #1;
            check_beat(nm, e, b, tg, 1'(e.n == 1));
            @(posedge i_clk); #1;
            i_ready = 1'b0;
        end
        chk({nm, ".done"}, 64'(o_valid), 64'd0);
        for (int d = 0; d < 4 && o_valid; d++) begin
            i_ready = 1'b1;
            @(posedge i_clk); #1;
        end
        i_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t           vecs [8];
        exp_t           e;
        decode_mem_op_t op;
        logic [31:0]    s1, off;
        logic [1:0]     sz;
        logic [3:0]     tg;

        vecs[0] = '{OP_MEM_LD,  32'h0000_1000, 32'h0, 2'd2, '{1, 32'h0000_1000, 32'h0000_1004, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0}};
        vecs[1] = '{OP_MEM_LD,  32'h0000_1000, 32'h1, 2'd1, '{1, 32'h0000_1000, 32'h0000_1004, 4'h6, 4'h0, 1'b1, 1'b1, 1'b0}};
        vecs[2] = '{OP_MEM_LD,  32'h0000_1000, 32'h3, 2'd2, '{2, 32'h0000_1000, 32'h0000_1004, 4'h8, 4'h7, 1'b1, 1'b1, 1'b0}};
        vecs[3] = '{OP_MEM_ST,  32'hFFFF_FFFE, 32'h1, 2'd2, '{2, 32'hFFFF_FFFC, 32'h0000_0000, 4'h8, 4'h7, 1'b0, 1'b1, 1'b0}};
        vecs[4] = '{OP_MEM_LDU, 32'h0000_2000, 32'h7, 2'd0, '{1, 32'h0000_2004, 32'h0000_2008, 4'h8, 4'h0, 1'b1, 1'b0, 1'b0}};
        vecs[5] = '{OP_MEM_LD,  32'h0000_1000, 32'h0, 2'd3, '{1, 32'h0000_1000, 32'h0000_1004, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1}};
        vecs[6] = '{OP_MEM_ST,  32'h0000_0010, 32'h2, 2'd1, '{1, 32'h0000_0010, 32'h0000_0014, 4'hC, 4'h0, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{OP_MEM_LD,  32'h0000_1001, 32'h2, 2'd1, '{2, 32'h0000_1000, 32'h0000_1004, 4'h8, 4'h1, 1'b1, 1'b1, 1'b0}};

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst.valid", 64'(o_valid), 64'd0);
        chk("rst.addr", 64'(o_addr), 64'd0);
        chk("rst.mask", 64'(o_mask), 64'd0);
        chk("rst.flags", 64'({o_ld, o_misalign, o_fault, o_beat, o_last, o_tag}), 64'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rst.ready", 64'(o_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            send($sformatf("vec%0d", i), vecs[i].op, vecs[i].src1, vecs[i].off, vecs[i].size, 4'(i + 3));
            collect($sformatf("vec%0d", i), vecs[i].e, 4'(i + 3), (i == 2) ? 3 : (i % 2));
        end

        // Flush while the first beat of a split is held: the second beat must never appear.
        send("flush2", OP_MEM_LD, 32'h1000, 32'h3, 2'd2, 4'h6);
        for (int s = 0; s < 2; s++) begin
            check_beat("flush2.hold", vecs[2].e, 0, 4'h6, 1'b0);
            @(posedge i_clk); #1;
        end
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        chk("flush2.valid", 64'(o_valid), 64'd0);
        chk("flush2.ready", 64'(o_ready), 64'd1);
        i_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(posedge i_clk); #1;
            chk("flush2.nobeat1", 64'(o_valid), 64'd0);
        end
        i_ready = 1'b0;

        // A request handshaking in the flush cycle is dropped.
        i_op = OP_MEM_LD; i_src1 = 32'h4000; i_offset = 32'h0; i_size = 2'd2; i_tag = 4'h9;
        i_valid = 1'b1; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        chk("flushacc.valid", 64'(o_valid), 64'd0);
        chk("flushacc.ready", 64'(o_ready), 64'd1);

        // Async reset in the middle of a split clears everything immediately.
        send("rstmid", OP_MEM_LD, 32'h1000, 32'h3, 2'd2, 4'h5);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rstmid.valid", 64'(o_valid), 64'd0);
        chk("rstmid.addr", 64'(o_addr), 64'd0);
        chk("rstmid.mask", 64'(o_mask), 64'd0);
        chk("rstmid.flags", 64'({o_ld, o_misalign, o_fault, o_beat, o_last, o_tag}), 64'd0);
        #3;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rstmid.ready", 64'(o_ready), 64'd1);
        i_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(posedge i_clk); #1;
            chk("rstmid.noreplay", 64'(o_valid), 64'd0);
        end
        i_ready = 1'b0;

        // No-split configuration: crossing access and doubleword both fault in one beat.
        for (int t = 0; t < 2; t++) begin
            i_op = OP_MEM_LD; i_src1 = 32'h1000; i_offset = (t == 0) ? 32'h3 : 32'h0;
            i_size = (t == 0) ? 2'd2 : 2'd3; i_tag = 4'hA;
            ns_valid = 1'b1;
            #1;
            chk("ns.accept", 64'(ns_o_ready), 64'd1);
            @(posedge i_clk); #1;
            ns_valid = 1'b0;
            ns_ready = 1'b1;
            #1;
            chk("ns.valid", 64'(ns_o_valid), 64'd1);
            chk("ns.mask", 64'(ns_o_mask), 64'd0);
            chk("ns.flags", 64'({ns_o_fault, ns_o_beat, ns_o_last, ns_o_ld}), 64'({1'b1, 1'b0, 1'b1, 1'b1}));
            chk("ns.misalign", 64'(ns_o_misalign), 64'((t == 0) ? 1'b1 : 1'b0));
            chk("ns.tag", 64'(ns_o_tag), 64'hA);
            @(posedge i_clk); #1;
            chk("ns.single", 64'(ns_o_valid), 64'd0);
            ns_ready = 1'b0;
        end

        for (int r = 0; r < 300; r++) begin
            op  = decode_mem_op_t'(2'($urandom_range(0, 3)));
            s1  = $urandom;
            if ($urandom_range(0, 3) == 0) s1 = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            off = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : 32'($urandom);
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            tg  = 4'($urandom_range(0, 15));
            e   = model(op, s1, off, sz, 1'b1);
            send("rnd", op, s1, off, sz, tg);
            collect("rnd", e, tg, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
